store_merge_ctrl: RTL and testbench
===================================

Name: store_merge_ctrl

Overview:
- Sequences one partial-word store into a line-wide data array as a read-modify-write.
- Accepts a store request with index, byte offset, 32-bit data and byte-valid mask.
- Reads the addressed line, overwrites the enabled bytes of the selected word, and writes the line back.
- Sits between the store pipeline and the cache data RAM; one request in flight at a time.

Parameters:
- WORD_WIDTH, 32: store data width in bits. Fixed at 4 bytes.
- WORD_COUNT, 4: words per line. Line width is WORD_COUNT*WORD_WIDTH.
- OFFSET_WIDTH, 4: byte offset width within a line.
- INDEX_WIDTH, 6: line index width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  store request present.
- req_ready  output  1  controller can accept a request.
- req_index  input  INDEX_WIDTH  target line index.
- req_offset  input  OFFSET_WIDTH  byte offset; [OFFSET_WIDTH-1:2] selects the word, [1:0] are ignored.
- req_wdata  input  WORD_WIDTH  store data.
- req_bval  input  4  byte enables; bit i controls wdata[8i+7:8i].
- mem_rd_en  output  1  line read strobe.
- mem_rd_index  output  INDEX_WIDTH  read index.
- mem_rd_data  input  WORD_COUNT*WORD_WIDTH  line data, valid exactly one cycle after mem_rd_en.
- mem_wr_en  output  1  line write strobe.
- mem_wr_index  output  INDEX_WIDTH  write index.
- mem_wr_data  output  WORD_COUNT*WORD_WIDTH  merged line.
- done  output  1  one-cycle pulse when a request completes.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: state IDLE. req_ready=1; mem_rd_en, mem_wr_en, done, busy=0. Index/data registers cleared to 0.
- Reset is honoured in any state. An in-progress RMW is abandoned and no write is issued.
- States: IDLE, READ, WAIT, WRITE, SKIP.
- IDLE: req_ready=1.
  - On req_valid&req_ready, register index, word select, wdata and bval.
  - If bval==0, go to SKIP; otherwise go to READ.
- READ: mem_rd_en=1 and mem_rd_index=registered index for exactly one cycle. Go to WAIT.
- WAIT: capture mem_rd_data into the line register. Go to WRITE.
- WRITE: for exactly one cycle, mem_wr_en=1, mem_wr_index=registered index, mem_wr_data=merged line, done=1. Go to IDLE.
- SKIP: done=1 for one cycle, no memory access. Go to IDLE.
- Merge rule: word w = offset[OFFSET_WIDTH-1:2] mod WORD_COUNT.
  - Byte b of word w takes wdata byte b when bval[b]=1; otherwise it keeps the read value.
  - All other words pass through unchanged.
- Latency: accept at cycle 0 -> mem_rd_en at cycle 1 -> data captured at cycle 2 -> mem_wr_en/done at cycle 3 -> req_ready at cycle 4.
- Throughput: one store per 4 cycles; a SKIP store takes 2 cycles.
- req_ready is 0 in all non-IDLE states. Request inputs are ignored while not ready; the requester holds them stable until accepted.
- mem_rd_en and mem_wr_en are never high in the same cycle. Index outputs are don't-care when their strobe is low; data outputs are also don't-care in that case.
- Back-to-back stores to the same line are correct by construction: the second read occurs after the first write.
- Outputs are registered or decoded from state only. There is no combinational path from req_* to mem_*.

Test Plan:
- Reset check: assert rst_n=0 -> req_ready=1, busy=0, all strobes and done=0.
- Full word: index 5, offset 0x8, wdata 0xDEADBEEF, bval 0xF; line read = 0x33333333_22222222_11111111_00000000.
  - Required: mem_rd_en at cycle 1.
  - Required: mem_wr_en at cycle 3 with index 5 and data 0x33333333_DEADBEEF_11111111_00000000.
  - Required: done at cycle 3.
- Partial bytes: offset 0x4, wdata 0xAABBCCDD, bval 0b0101; line read all 0xFF.
  - Required: word 1 written as 0xFFBBFFDD; other words stay 0xFFFFFFFF.
- Offset low bits ignored: offset 0xF, bval 0xF, wdata 0x12345678 -> word 3 is replaced.
- bval=0: request accepted, done pulses at cycle 1, mem_rd_en and mem_wr_en never assert, req_ready=1 at cycle 2.
- Back-to-back and reset mid-op:
  - Two stores to index 9 (word 0 bval 0x1 data 0x000000AA, then word 0 bval 0x2 data 0x0000BB00); the memory model returns the last written value, initial 0.
  - Required: final write is 0x0000BBAA.
  - Separately: drop rst_n during WAIT -> no mem_wr_en is issued, and the controller is in IDLE after release.

Source files
------------

// File: rtl/store_merge_ctrl.sv
// Read-modify-write sequencer for one partial-word store into a line-wide data RAM.
// One request in flight; all memory-side outputs come from registers or state decode.
module store_merge_ctrl #(
  parameter int WORD_WIDTH   = 32,
  parameter int WORD_COUNT   = 4,
  parameter int OFFSET_WIDTH = 4,
  parameter int INDEX_WIDTH  = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [INDEX_WIDTH-1:0]           req_index,
  input  logic [OFFSET_WIDTH-1:0]          req_offset,
  input  logic [WORD_WIDTH-1:0]            req_wdata,
  input  logic [3:0]                       req_bval,
  output logic                             mem_rd_en,
  output logic [INDEX_WIDTH-1:0]           mem_rd_index,
  input  logic [WORD_COUNT*WORD_WIDTH-1:0] mem_rd_data,
  output logic                             mem_wr_en,
  output logic [INDEX_WIDTH-1:0]           mem_wr_index,
  output logic [WORD_COUNT*WORD_WIDTH-1:0] mem_wr_data,
  output logic                             done,
  output logic                             busy
);

  localparam int LINE_W = WORD_COUNT * WORD_WIDTH;
  localparam int SEL_W  = OFFSET_WIDTH - 2;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, SKIP} state_t;

  state_t                  state, state_nxt;
  logic [INDEX_WIDTH-1:0]  index_q;
  logic [SEL_W-1:0]        sel_q;
  logic [WORD_WIDTH-1:0]   wdata_q;
  logic [3:0]              bval_q;
  logic [LINE_W-1:0]       line_q;
  logic                    accept;
  logic                    unused_offset_lsb;

  // Byte-lane offset bits do not affect which word is merged.
  assign unused_offset_lsb = ^req_offset[1:0];

  function automatic logic [LINE_W-1:0] merge_line(
    input logic [LINE_W-1:0]     line,
    input logic [SEL_W-1:0]      sel,
    input logic [WORD_WIDTH-1:0] wdata,
    input logic [3:0]            bval
  );
    logic [LINE_W-1:0] res;
    int                w;
    res = line;
    w   = int'(sel) % WORD_COUNT;
    for (int b = 0; b < 4; b++) begin
      if (bval[b]) res[w*WORD_WIDTH + 8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  assign accept = req_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nxt = (req_bval == 4'b0) ? SKIP : READ;
      end
      READ: begin
        mem_rd_en = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: state_nxt = WRITE;
      WRITE: begin
        mem_wr_en = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      SKIP: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture on accept; read line captured in WAIT, one cycle after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      bval_q  <= '0;
      line_q  <= '0;
    end else begin
      if (accept) begin
        index_q <= req_index;
        sel_q   <= req_offset[OFFSET_WIDTH-1:2];
        wdata_q <= req_wdata;
        bval_q  <= req_bval;
      end
      if (state == WAIT) line_q <= mem_rd_data;
    end
  end

  assign mem_rd_index = index_q;
  assign mem_wr_index = index_q;
  assign mem_wr_data  = merge_line(line_q, sel_q, wdata_q, bval_q);

endmodule

// File: tb/tb_store_merge_ctrl.sv
// Directed bench for store_merge_ctrl with a small line memory model.
module tb_store_merge_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [5:0]   req_index;
  logic [3:0]   req_offset;
  logic [31:0]  req_wdata;
  logic [3:0]   req_bval;
  logic         mem_rd_en;
  logic [5:0]   mem_rd_index;
  logic [127:0] mem_rd_data;
  logic         mem_wr_en;
  logic [5:0]   mem_wr_index;
  logic [127:0] mem_wr_data;
  logic         done;
  logic         busy;

  logic [127:0] mem [64];
  logic         pl_en;
  logic [5:0]   pl_idx;
  logic [127:0] pl_data;
  int           wr_cnt = 0;
  int           rd_cnt = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  int           wr_snap, rd_snap;

  store_merge_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_offset(req_offset), .req_wdata(req_wdata), .req_bval(req_bval),
    .mem_rd_en(mem_rd_en), .mem_rd_index(mem_rd_index), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_index(mem_wr_index), .mem_wr_data(mem_wr_data),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Line memory: one-cycle read latency, write-through, plus a preload port.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_rd_index];
      rd_cnt      <= rd_cnt + 1;
    end
    if (mem_wr_en) begin
      mem[mem_wr_index] <= mem_wr_data;
      wr_cnt            <= wr_cnt + 1;
    end
    if (pl_en) mem[pl_idx] <= pl_data;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [127:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Presents a request at a negedge; returns just after the accepting edge (cycle 0).
  task automatic issue(input logic [5:0] idx, input logic [3:0] off,
                       input logic [31:0] wd, input logic [3:0] bv);
    @(negedge clk);
    req_valid = 1'b1; req_index = idx; req_offset = off; req_wdata = wd; req_bval = bv;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Runs a full RMW and checks the write cycle.
  task automatic rmw_check(input string tag, input logic [5:0] idx, input logic [3:0] off,
                           input logic [31:0] wd, input logic [3:0] bv,
                           input logic [127:0] exp_line);
    issue(idx, off, wd, bv);
    @(negedge clk);
    check({tag, "_rd_en_c1"}, 128'(mem_rd_en), 128'd1);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_wr_en_c3"}, 128'(mem_wr_en), 128'd1);
    check({tag, "_wr_data"}, mem_wr_data, exp_line);
    @(negedge clk);
    check({tag, "_ready_c4"}, 128'(req_ready), 128'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_index = '0; req_offset = '0;
    req_wdata = '0; req_bval = '0; pl_en = 1'b0; pl_idx = '0; pl_data = '0;

    repeat (2) @(negedge clk);
    check("rst_ready", 128'(req_ready), 128'd1);
    check("rst_busy",  128'(busy),      128'd0);
    check("rst_rd_en", 128'(mem_rd_en), 128'd0);
    check("rst_wr_en", 128'(mem_wr_en), 128'd0);
    check("rst_done",  128'(done),      128'd0);
    rst_n = 1'b1;

    // Full word store, cycle-by-cycle
    preload(6'd5, 128'h33333333_22222222_11111111_00000000);
    issue(6'd5, 4'h8, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    check("full_rd_en_c1",  128'(mem_rd_en),    128'd1);
    check("full_rd_idx_c1", 128'(mem_rd_index), 128'd5);
    check("full_wr_en_c1",  128'(mem_wr_en),    128'd0);
    check("full_ready_c1",  128'(req_ready),    128'd0);
    check("full_busy_c1",   128'(busy),         128'd1);
    check("full_done_c1",   128'(done),         128'd0);
    @(negedge clk);
    check("full_rd_en_c2",  128'(mem_rd_en),    128'd0);
    check("full_wr_en_c2",  128'(mem_wr_en),    128'd0);
    check("full_done_c2",   128'(done),         128'd0);
    @(negedge clk);
    check("full_wr_en_c3",  128'(mem_wr_en),    128'd1);
    check("full_rd_en_c3",  128'(mem_rd_en),    128'd0);
    check("full_wr_idx_c3", 128'(mem_wr_index), 128'd5);
    check("full_wr_data",   mem_wr_data, 128'h33333333_DEADBEEF_11111111_00000000);
    check("full_done_c3",   128'(done),         128'd1);
    @(negedge clk);
    check("full_ready_c4",  128'(req_ready),    128'd1);
    check("full_done_c4",   128'(done),         128'd0);
    check("full_busy_c4",   128'(busy),         128'd0);

    // Partial bytes into word 1
    preload(6'd2, {4{32'hFFFFFFFF}});
    rmw_check("part", 6'd2, 4'h4, 32'hAABBCCDD, 4'b0101,
              128'hFFFFFFFF_FFFFFFFF_FFBBFFDD_FFFFFFFF);

    // Offset byte bits ignored: 0xF selects word 3
    preload(6'd3, 128'h33333333_22222222_11111111_00000000);
    rmw_check("offlo", 6'd3, 4'hF, 32'h12345678, 4'hF,
              128'h12345678_22222222_11111111_00000000);

    // Empty byte mask: SKIP path, no memory traffic
    wr_snap = wr_cnt; rd_snap = rd_cnt;
    issue(6'd7, 4'h0, 32'hCAFEF00D, 4'h0);
    @(negedge clk);
    check("skip_done_c1",  128'(done),      128'd1);
    check("skip_rd_en_c1", 128'(mem_rd_en), 128'd0);
    check("skip_wr_en_c1", 128'(mem_wr_en), 128'd0);
    check("skip_busy_c1",  128'(busy),      128'd1);
    @(negedge clk);
    check("skip_ready_c2", 128'(req_ready), 128'd1);
    check("skip_done_c2",  128'(done),      128'd0);
    check("skip_wr_cnt",   128'(wr_cnt - wr_snap), 128'd0);
    check("skip_rd_cnt",   128'(rd_cnt - rd_snap), 128'd0);

    // Back-to-back stores to the same line
    preload(6'd9, 128'h0);
    rmw_check("b2b1", 6'd9, 4'h0, 32'h000000AA, 4'h1, 128'h000000AA);
    rmw_check("b2b2", 6'd9, 4'h0, 32'h0000BB00, 4'h2, 128'h0000BBAA);
    @(negedge clk);
    check("b2b_mem", mem[9], 128'h0000BBAA);

    // Reset dropped in WAIT abandons the write
    preload(6'd10, 128'h0);
    issue(6'd10, 4'h4, 32'h11223344, 4'hF);
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_wait", 128'(busy), 128'd1);
    wr_snap = wr_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 128'(req_ready), 128'd1);
    check("mid_rst_busy",  128'(busy),      128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_wr_cnt",    128'(wr_cnt - wr_snap), 128'd0);
    check("mid_ready",     128'(req_ready), 128'd1);
    check("mid_busy",      128'(busy),      128'd0);
    check("mid_mem",       mem[10],         128'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
